// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: opcode constants, bypass select encoding and decoded
// instruction record shared by the hazard/forwarding controller.
package hazard_unit_pkg;

    // Execute-stage operand source select.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        MX   = 2'b01,
        WX   = 2'b10
    } bypass_t;

    // Major opcodes (inst[6:0]).
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;

    // addi x0,x0,0 -- the bubble injected into X.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Register usage of one instruction.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reads_rs1;
        logic       reads_rs2;
        logic       writes_rd;   // already excludes rd == x0
        logic       is_load;
    } dec_t;

    // Forwarding source for one operand of the X instruction.
    // A load in M has no data yet, so it never forwards; W is the fallback.
    function automatic bypass_t pick_bypass(input logic [4:0] src, input logic reads,
                                            input dec_t m, input dec_t w);
        if (!reads || src == 5'd0)
            return NONE;
        if (m.writes_rd && m.rd == src && !m.is_load)
            return MX;
        if (w.writes_rd && w.rd == src)
            return WX;
        return NONE;
    endfunction

    // True when consumer reads a register that producer writes.
    function automatic logic depends_on(input dec_t consumer, input dec_t producer);
        return producer.writes_rd &&
               ((consumer.reads_rs1 && consumer.rs1 == producer.rd) ||
                (consumer.reads_rs2 && consumer.rs2 == producer.rd));
    endfunction

endpackage

// File: rtl/hazard_unit_decode.sv
// hazard_decode: combinational register-usage decode of one 32-bit instruction.
module hazard_decode
    import hazard_unit_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign opcode = inst[6:0];

    // funct3/funct7 do not affect register usage.
    assign unused_fields = ^{inst[31:25], inst[14:12]};

    // Classify the opcode into which register fields it reads and writes.
    always_comb begin
        dec.rs1       = inst[19:15];
        dec.rs2       = inst[24:20];
        dec.rd        = inst[11:7];
        dec.reads_rs1 = opcode inside {JALR, BCC, LCC, SCC, MCC, RCC};
        dec.reads_rs2 = opcode inside {BCC, SCC, RCC};
        dec.writes_rd = (opcode inside {LUI, AUIPC, JAL, JALR, LCC, MCC, RCC}) &&
                        (inst[11:7] != 5'd0);
        dec.is_load   = (opcode == LCC);
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects and fetch/decode stall control for the
// 5-stage pipeline, driven by a shadow copy of the X/M/W instructions.
// Build option HAZARD_BYPASS_EN: when defined, MX/WX forwarding plus a
// one-cycle load-use stall; when undefined, no forwarding and D stalls while
// any producer of its sources is still in X or M.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_d,
    input  logic        kill_dx,
    output logic [1:0]  rs1_bypass,
    output logic [1:0]  rs2_bypass,
    output logic        stall_fd,
    output logic        bubble_x
);

    logic [31:0] x_inst, m_inst, w_inst;
    dec_t        d_dec, x_dec, m_dec, w_dec;
    bypass_t     rs1_sel, rs2_sel;
    logic        hazard;
    logic        unused_dec;

    hazard_decode u_dec_d (.inst(inst_d), .dec(d_dec));
    hazard_decode u_dec_x (.inst(x_inst), .dec(x_dec));
    hazard_decode u_dec_m (.inst(m_inst), .dec(m_dec));
    hazard_decode u_dec_w (.inst(w_inst), .dec(w_dec));

    // Not every decoded field is consulted for every stage.
    assign unused_dec = ^{d_dec, x_dec, m_dec, w_dec};

    // Shadow pipeline: X takes D unless flushed or bubbled; M/W just follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_inst <= NOP;
            m_inst <= NOP;
            w_inst <= NOP;
        end else begin
            if (kill_dx || stall_fd)
                x_inst <= NOP;
            else
                x_inst <= inst_d;
            m_inst <= x_inst;
            w_inst <= m_inst;
        end
    end

    // Forwarding selects and stall detection; kill_dx suppresses the stall
    // because the D instruction is being flushed anyway.
    always_comb begin
        rs1_sel = NONE;
        rs2_sel = NONE;
        hazard  = 1'b0;
`ifdef HAZARD_BYPASS_EN
        rs1_sel = pick_bypass(x_dec.rs1, x_dec.reads_rs1, m_dec, w_dec);
        rs2_sel = pick_bypass(x_dec.rs2, x_dec.reads_rs2, m_dec, w_dec);
        // A load in X cannot forward next cycle via MX; delay the consumer
        // one cycle so it picks the value up via WX.
        hazard  = x_dec.is_load && depends_on(d_dec, x_dec);
`else
        hazard  = depends_on(d_dec, x_dec) || depends_on(d_dec, m_dec);
`endif
        stall_fd = hazard && !kill_dx;
        bubble_x = hazard && !kill_dx;
    end

    assign rs1_bypass = rs1_sel;
    assign rs2_bypass = rs2_sel;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed test-plan sequences plus randomized instruction
// streams, all checked against a reference model of the X/M/W history.
module tb_hazard_unit;

    localparam logic [6:0] T_LUI   = 7'h37;
    localparam logic [6:0] T_AUIPC = 7'h17;
    localparam logic [6:0] T_JAL   = 7'h6f;
    localparam logic [6:0] T_JALR  = 7'h67;
    localparam logic [6:0] T_BCC   = 7'h63;
    localparam logic [6:0] T_LCC   = 7'h03;
    localparam logic [6:0] T_SCC   = 7'h23;
    localparam logic [6:0] T_MCC   = 7'h13;
    localparam logic [6:0] T_RCC   = 7'h33;
    localparam logic [31:0] T_NOP  = 32'h0000_0013;

    localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1X1 = 32'h0010_8133;
    localparam logic [31:0] ADD_X6_X1X0 = 32'h0000_8333;
    localparam logic [31:0] LW_X5       = 32'h0001_2283;
    localparam logic [31:0] ADD_X6_X5X0 = 32'h0002_8333;
    localparam logic [31:0] ADD_X6_X5X1 = 32'h0012_8333;
    localparam logic [31:0] ADDI_X0_1   = 32'h0010_0013;
    localparam logic [31:0] ADD_X5_X0X0 = 32'h0000_02b3;
    localparam logic [31:0] ADDI_X3_1   = 32'h0010_0193;
    localparam logic [31:0] ADDI_X3_2   = 32'h0020_0193;
    localparam logic [31:0] ADD_X4_X3X0 = 32'h0001_8233;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_d;
    logic        kill_dx;
    logic [1:0]  rs1_bypass, rs2_bypass;
    logic        stall_fd, bubble_x;

    int checks   = 0;
    int failures = 0;

    // Instructions that have entered X, oldest first: [0]=W, [1]=M, [2]=X.
    logic [31:0] hist[$];
    logic [31:0] cur_inst;
    logic        cur_kill, cur_rst, exp_stall;

    hazard_unit dut (
        .clk(clk), .reset(reset), .inst_d(inst_d), .kill_dx(kill_dx),
        .rs1_bypass(rs1_bypass), .rs2_bypass(rs2_bypass),
        .stall_fd(stall_fd), .bubble_x(bubble_x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int src1(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        int r = int'(i[19:15]);
        if (r != 0 && (op == T_JALR || op == T_BCC || op == T_LCC || op == T_SCC ||
                       op == T_MCC || op == T_RCC))
            return r;
        return -2;
    endfunction

    function automatic int src2(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        int r = int'(i[24:20]);
        if (r != 0 && (op == T_BCC || op == T_SCC || op == T_RCC))
            return r;
        return -2;
    endfunction

    function automatic int dest(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        int r = int'(i[11:7]);
        if (r != 0 && (op == T_LUI || op == T_AUIPC || op == T_JAL || op == T_JALR ||
                       op == T_LCC || op == T_MCC || op == T_RCC))
            return r;
        return -1;
    endfunction

    function automatic bit needs(input logic [31:0] d, input logic [31:0] p);
        return dest(p) >= 0 && (src1(d) == dest(p) || src2(d) == dest(p));
    endfunction

    function automatic logic [1:0] sel(input int s, input logic [31:0] m, input logic [31:0] w);
        if (s < 0) return 2'd0;
        if (dest(m) == s && m[6:0] != T_LCC) return 2'd1;
        if (dest(w) == s) return 2'd2;
        return 2'd0;
    endfunction

    // ---------------- driver tasks ----------------
    // Apply inputs mid-cycle and compare every output with the model.
    task automatic drive(input logic [31:0] inst, input logic kill, input logic rst);
        logic [31:0] xi, mi, wi;
        logic [1:0]  e1, e2;
        logic        st;
        @(negedge clk);
        inst_d = inst; kill_dx = kill; reset = rst;
        cur_inst = inst; cur_kill = kill; cur_rst = rst;
        #1;
        wi = hist[0]; mi = hist[1]; xi = hist[2];
`ifdef HAZARD_BYPASS_EN
        e1 = sel(src1(xi), mi, wi);
        e2 = sel(src2(xi), mi, wi);
        st = xi[6:0] == T_LCC && needs(inst, xi);
`else
        e1 = 2'd0;
        e2 = 2'd0;
        st = needs(inst, xi) || needs(inst, mi);
`endif
        if (kill) st = 1'b0;
        exp_stall = st;
        check("rs1_bypass", {30'd0, rs1_bypass}, {30'd0, e1});
        check("rs2_bypass", {30'd0, rs2_bypass}, {30'd0, e2});
        check("stall_fd", {31'd0, stall_fd}, {31'd0, st});
        check("bubble_x", {31'd0, bubble_x}, {31'd0, st});
    endtask

    // Clock edge: advance the model history the same way the pipeline moves.
    task automatic advance();
        @(posedge clk);
        if (cur_rst) begin
            hist = {T_NOP, T_NOP, T_NOP};
        end else begin
            void'(hist.pop_front());
            hist.push_back((cur_kill || exp_stall) ? T_NOP : cur_inst);
        end
    endtask

    task automatic step(input logic [31:0] inst, input logic kill, input logic rst);
        drive(inst, kill, rst);
        advance();
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(T_NOP, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[9] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BCC, T_LCC, T_SCC, T_MCC, T_RCC};
        logic [4:0] rd  = 5'($urandom_range(0, 3));
        logic [4:0] ra  = 5'($urandom_range(0, 3));
        logic [4:0] rb  = 5'($urandom_range(0, 3));
        logic [2:0] f3  = 3'($urandom_range(0, 7));
        return {7'd0, rb, ra, f3, rd, ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        logic [31:0] held;
        bit          hold;
        reset = 1'b1; inst_d = T_NOP; kill_dx = 1'b0;
        @(posedge clk);
        hist = {T_NOP, T_NOP, T_NOP};

        // Reset state
        drive(T_NOP, 1'b0, 1'b1);
        check("reset_rs1", {30'd0, rs1_bypass}, 32'd0);
        check("reset_stall", {31'd0, stall_fd}, 32'd0);
        advance();
        step(T_NOP, 1'b0, 1'b1);

        // MX bypass
        step(ADDI_X1_5, 1'b0, 1'b0);
        drive(ADD_X2_X1X1, 1'b0, 1'b0);
`ifdef HAZARD_BYPASS_EN
        check("mx_nostall", {31'd0, stall_fd}, 32'd0);
        advance();
        drive(T_NOP, 1'b0, 1'b0);
        check("mx_rs1", {30'd0, rs1_bypass}, 32'd1);
        check("mx_rs2", {30'd0, rs2_bypass}, 32'd1);
        advance();
`else
        check("dep_stall_x", {31'd0, stall_fd}, 32'd1);
        advance();
        drive(ADD_X2_X1X1, 1'b0, 1'b0);
        check("dep_stall_m", {31'd0, stall_fd}, 32'd1);
        advance();
        drive(ADD_X2_X1X1, 1'b0, 1'b0);
        check("dep_release", {31'd0, stall_fd}, 32'd0);
        advance();
`endif
        flush();

        // WX bypass
        step(ADDI_X1_5, 1'b0, 1'b0);
        step(T_NOP, 1'b0, 1'b0);
        step(ADD_X6_X1X0, 1'b0, 1'b0);
        drive(T_NOP, 1'b0, 1'b0);
`ifdef HAZARD_BYPASS_EN
        check("wx_rs1", {30'd0, rs1_bypass}, 32'd2);
        check("wx_rs2", {30'd0, rs2_bypass}, 32'd0);
`endif
        advance();
        flush();

        // Load-use
        step(LW_X5, 1'b0, 1'b0);
        drive(ADD_X6_X5X0, 1'b0, 1'b0);
        check("lu_stall", {31'd0, stall_fd}, 32'd1);
        check("lu_bubble", {31'd0, bubble_x}, 32'd1);
        advance();
        drive(ADD_X6_X5X0, 1'b0, 1'b0);
`ifdef HAZARD_BYPASS_EN
        check("lu_one_cycle", {31'd0, stall_fd}, 32'd0);
        advance();
        drive(T_NOP, 1'b0, 1'b0);
        check("lu_wx", {30'd0, rs1_bypass}, 32'd2);
`endif
        advance();
        flush();

        // x0 never forwards or stalls
        step(ADDI_X0_1, 1'b0, 1'b0);
        drive(ADD_X5_X0X0, 1'b0, 1'b0);
        check("x0_stall", {31'd0, stall_fd}, 32'd0);
        advance();
        drive(T_NOP, 1'b0, 1'b0);
        check("x0_rs1", {30'd0, rs1_bypass}, 32'd0);
        check("x0_rs2", {30'd0, rs2_bypass}, 32'd0);
        advance();
        flush();

        // M beats W
        step(ADDI_X3_1, 1'b0, 1'b0);
        step(ADDI_X3_2, 1'b0, 1'b0);
        step(ADD_X4_X3X0, 1'b0, 1'b0);
        drive(T_NOP, 1'b0, 1'b0);
`ifdef HAZARD_BYPASS_EN
        check("prio_mx", {30'd0, rs1_bypass}, 32'd1);
`endif
        advance();
        flush();

        // Kill overrides load-use; X must then hold a bubble
        step(ADDI_X1_5, 1'b0, 1'b0);
        step(LW_X5, 1'b0, 1'b0);
        drive(ADD_X6_X5X1, 1'b1, 1'b0);
        check("kill_stall", {31'd0, stall_fd}, 32'd0);
        check("kill_bubble", {31'd0, bubble_x}, 32'd0);
        advance();
        drive(T_NOP, 1'b0, 1'b0);
        check("kill_x_nop_rs2", {30'd0, rs2_bypass}, 32'd0);
        advance();
        flush();

        // Reset during a load-use stall
        step(LW_X5, 1'b0, 1'b0);
        drive(ADD_X6_X5X0, 1'($urandom_range(0, 1)), 1'b1);
        advance();
        drive(ADD_X6_X5X0, 1'b0, 1'b0);
        check("rst_rs1", {30'd0, rs1_bypass}, 32'd0);
        check("rst_rs2", {30'd0, rs2_bypass}, 32'd0);
        check("rst_stall", {31'd0, stall_fd}, 32'd0);
        check("rst_bubble", {31'd0, bubble_x}, 32'd0);
        advance();
        step(ADDI_X1_5, 1'b0, 1'b0);
        step(ADD_X2_X1X1, 1'b0, 1'b0);
        drive(T_NOP, 1'b0, 1'b0);
`ifdef HAZARD_BYPASS_EN
        check("rst_resume_mx", {30'd0, rs1_bypass}, 32'd1);
`endif
        advance();

        // Randomized streams; a stalled D instruction is re-presented.
        hold = 0;
        held = T_NOP;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] nxt;
            logic        k, r;
            nxt = hold ? held : rand_inst();
            k = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 49) == 0);
            drive(nxt, k, r);
            hold = exp_stall && !r;
            held = nxt;
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
